// File: rtl/bus_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter_if
// Bundle of the shared-bus handshake between the driver FIFOs and the
// central arbiter.
//   pndng   : per-driver FIFO not-empty flags
//   D_pop   : per-driver FIFO head packets (valid while pndng[i]=1)
//   pop     : one-cycle pop strobe to the granted FIFO
//   push    : one-cycle push strobe to destination driver(s)
//   D_push  : packet presented to destinations (same value on every lane)
//   busy    : arbiter is in the middle of a transfer
//   drop    : popped packet had no legal destination
// Modports: master = arbiter side, slave = driver/FIFO side.
// ---------------------------------------------------------------------------
interface bus_rr_arbiter_if #(
   parameter int pckg_sz = 16,
   parameter int drvrs   = 4
);
   logic [drvrs-1:0]              pndng;
   logic [drvrs-1:0][pckg_sz-1:0] D_pop;
   logic [drvrs-1:0]              pop;
   logic [drvrs-1:0]              push;
   logic [drvrs-1:0][pckg_sz-1:0] D_push;
   logic                          busy;
   logic                          drop;

   modport master (
      input  pndng, D_pop,
      output pop, push, D_push, busy, drop
   );

   modport slave (
      output pndng, D_pop,
      input  pop, push, D_push, busy, drop
   );
endinterface

// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
// Round-robin arbiter and router for the shared broadcast bus. Grants one
// pending driver FIFO, pops its head packet, decodes the destination ID in
// the packet's upper ID_W bits and pushes it to the destination driver, or to
// every other driver for a broadcast ID. Unroutable packets raise drop.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : bus_rr_arbiter_if.master (pndng/D_pop in; pop/push/D_push/busy/drop out)
// One transfer takes IDLE -> GRANT -> PUSH, i.e. at most one packet per 3 cycles.
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
   parameter int              pckg_sz = 16,
   parameter int              drvrs   = 4,
   parameter int              ID_W    = 8,
   parameter logic [ID_W-1:0] BCAST   = ID_W'(8'hFF)
) (
   input  logic              clk,
   input  logic              reset,
   bus_rr_arbiter_if.master  bus
);

   localparam int GW = $clog2(drvrs);

   typedef enum logic [1:0] {IDLE, GRANT, PUSH} state_t;

   state_t             state_q, state_d;
   logic [GW-1:0]      rr_ptr;
   logic [GW-1:0]      gnt_q;
   logic [GW-1:0]      winner;
   logic [pckg_sz-1:0] pkt_q;

   logic [ID_W-1:0]    dest;
   logic [GW-1:0]      dest_idx;
   logic               dest_ok;

   logic [drvrs-1:0]   pop_d;
   logic [drvrs-1:0]   push_d;
   logic               drop_d;

   // Rotating priority search starting at rr_ptr. Scanning from the farthest
   // offset down lets the nearest pending driver overwrite the result last.
   always_comb begin
      winner = rr_ptr;
      for (int k = drvrs - 1; k >= 0; k--) begin
         if (bus.pndng[(int'(rr_ptr) + k) % drvrs]) begin
            winner = GW'((int'(rr_ptr) + k) % drvrs);
         end
      end
   end

   // Destination decode from the latched packet.
   assign dest     = pkt_q[pckg_sz-1 -: ID_W];
   assign dest_idx = GW'(dest);
   assign dest_ok  = (32'(dest) < 32'(drvrs)) && (dest_idx != gnt_q);

   // Next-state and strobe decode; outputs depend on registered state only.
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      pop_d   = '0;
      push_d  = '0;
      drop_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|bus.pndng) state_d = GRANT;
         end
         GRANT: begin
            pop_d[gnt_q] = 1'b1;
            state_d      = PUSH;
         end
         PUSH: begin
            if (dest == BCAST) begin
               push_d        = '1;
               push_d[gnt_q] = 1'b0;
            end else if (dest_ok) begin
               push_d[dest_idx] = 1'b1;
            end else begin
               drop_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Datapath registers: grant index, packet latch and round-robin pointer.
   // NOTE: pkt_q is reset because it drives D_push directly and D_push must read 0 out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_q  <= '0;
         rr_ptr <= '0;
         pkt_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE:  if (|bus.pndng) gnt_q <= winner;
            GRANT: pkt_q <= bus.D_pop[gnt_q];
            PUSH:  rr_ptr <= (int'(gnt_q) == drvrs - 1) ? '0 : gnt_q + 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.pop    = pop_d;
   assign bus.push   = push_d;
   assign bus.drop   = drop_d;
   assign bus.busy   = (state_q != IDLE);
   assign bus.D_push = {drvrs{pkt_q}};

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_rr_arbiter
// Directed bench for bus_rr_arbiter. A transaction-level model predicts
// pop/push/drop/busy/D_push for every cycle from the arbitration and routing
// rules; a compare process checks the DUT against it on each falling edge.
// Directed steps additionally pin key cycles to hand-computed literals.
// ---------------------------------------------------------------------------
module tb_bus_rr_arbiter;

   localparam int PW = 16;
   localparam int ND = 4;

   logic clk = 1'b0;
   logic reset;

   bus_rr_arbiter_if #(.pckg_sz(PW), .drvrs(ND)) bus ();

   bus_rr_arbiter #(
      .pckg_sz(PW),
      .drvrs  (ND),
      .ID_W   (8),
      .BCAST  (8'hFF)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A transfer is remembered as (source, cycles since grant); the expected
   // outputs for the cycle after each edge are derived from that.
   int              txn_age   = -1;   // -1: no transfer in flight
   int              txn_src   = 0;
   int              next_rr   = 0;
   logic [ND-1:0]   e_pop     = '0;
   logic [ND-1:0]   e_push    = '0;
   logic            e_drop    = 1'b0;
   logic            e_busy    = 1'b0;
   logic [PW-1:0]   e_pkt     = '0;
   bit              model_ok  = 1'b0;

   always @(posedge clk) begin
      e_pop  = '0;
      e_push = '0;
      e_drop = 1'b0;
      if (reset) begin
         txn_age = -1;
         next_rr = 0;
         e_busy  = 1'b0;
         e_pkt   = '0;
      end else if (txn_age < 0) begin
         if (bus.pndng != '0) begin
            // First pending driver at or after next_rr, wrapping.
            for (int k = ND - 1; k >= 0; k--) begin
               if (bus.pndng[(next_rr + k) % ND]) txn_src = (next_rr + k) % ND;
            end
            txn_age = 0;
            e_pop[txn_src] = 1'b1;
            e_busy = 1'b1;
         end else begin
            e_busy = 1'b0;
         end
      end else if (txn_age == 0) begin
         int dst;
         e_pkt = bus.D_pop[txn_src];
         dst   = int'(e_pkt[PW-1 -: 8]);
         if (dst == 255) begin
            for (int i = 0; i < ND; i++) e_push[i] = (i != txn_src);
         end else if (dst < ND && dst != txn_src) begin
            e_push[dst] = 1'b1;
         end else begin
            e_drop = 1'b1;
         end
         next_rr = (txn_src + 1) % ND;
         txn_age = 1;
         e_busy  = 1'b1;
      end else begin
         txn_age = -1;
         e_busy  = 1'b0;
      end
      model_ok = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (model_ok) begin
         check("pop",    64'(bus.pop),    64'(e_pop));
         check("push",   64'(bus.push),   64'(e_push));
         check("drop",   64'(bus.drop),   64'(e_drop));
         check("busy",   64'(bus.busy),   64'(e_busy));
         check("D_push", 64'(bus.D_push), 64'({ND{e_pkt}}));
         check("pop_push_excl", 64'(|(bus.pop) & |(bus.push)), 64'(0));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      bus.pndng = 4'hF;
      bus.D_pop[0] = 16'h0111;
      bus.D_pop[1] = 16'h0222;
      bus.D_pop[2] = 16'h0333;
      bus.D_pop[3] = 16'h0000;

      // 1. Reset with all drivers pending.
      tick();
      check("rst_pop",    64'(bus.pop),    64'h0);
      check("rst_push",   64'(bus.push),   64'h0);
      check("rst_D_push", 64'(bus.D_push), 64'h0);
      check("rst_busy",   64'(bus.busy),   64'h0);
      check("rst_drop",   64'(bus.drop),   64'h0);
      tick();
      check("rst2_pop",   64'(bus.pop),    64'h0);
      reset = 1'b0;
      tick();                                   // first sampling edge
      check("first_gnt_pop", 64'(bus.pop), 64'h1);
      bus.pndng = '0;
      tick();
      check("first_gnt_push", 64'(bus.push), 64'h2);
      tick();
      check("first_gnt_idle", 64'(bus.busy), 64'h0);

      // 2. Single unicast from driver 1 to driver 2.
      bus.pndng    = 4'b0010;
      bus.D_pop[1] = 16'h02AB;
      tick();
      check("uni_pop",  64'(bus.pop),  64'h2);
      check("uni_busy1", 64'(bus.busy), 64'h1);
      bus.pndng = '0;
      tick();
      check("uni_push",  64'(bus.push),   64'h4);
      check("uni_data",  64'(bus.D_push), 64'h02AB_02AB_02AB_02AB);
      check("uni_busy2", 64'(bus.busy),   64'h1);
      tick();
      check("uni_idle",  64'(bus.busy),   64'h0);

      // 4. Broadcast from driver 2.
      bus.pndng    = 4'b0100;
      bus.D_pop[2] = 16'hFF55;
      tick();
      check("bc_pop", 64'(bus.pop), 64'h4);
      bus.pndng = '0;
      tick();
      check("bc_push", 64'(bus.push),   64'hB);
      check("bc_data", 64'(bus.D_push), 64'hFF55_FF55_FF55_FF55);
      check("bc_drop", 64'(bus.drop),   64'h0);
      tick();

      // 5a. Self-addressed packet from driver 3 is dropped; pointer wraps to 0.
      bus.pndng    = 4'b1000;
      bus.D_pop[3] = 16'h0399;
      tick();
      check("self_pop", 64'(bus.pop), 64'h8);
      bus.pndng = '0;
      tick();
      check("self_push", 64'(bus.push), 64'h0);
      check("self_drop", 64'(bus.drop), 64'h1);
      tick();
      check("self_drop_end", 64'(bus.drop), 64'h0);

      // 3. Round robin with everyone pending, each addressed to src+1.
      bus.D_pop[0] = 16'h0110;
      bus.D_pop[1] = 16'h0221;
      bus.D_pop[2] = 16'h0332;
      bus.D_pop[3] = 16'h0043;
      bus.pndng    = 4'hF;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_pop", 64'(bus.pop), 64'(4'b0001 << (k % 4)));
         if (k == 4) bus.pndng = '0;
         tick();
         check("rr_push", 64'(bus.push), 64'(4'b0001 << ((k + 1) % 4)));
         tick();
         check("rr_gap", 64'(bus.pop), 64'h0);
      end

      // 5b. Out-of-range destination from driver 0 is dropped.
      bus.pndng    = 4'b0001;
      bus.D_pop[0] = 16'h0712;
      tick();
      check("oor_pop", 64'(bus.pop), 64'h1);
      bus.pndng = '0;
      tick();
      check("oor_push", 64'(bus.push), 64'h0);
      check("oor_drop", 64'(bus.drop), 64'h1);
      tick();
      // Pointer advanced past 0 even though the packet was dropped.
      bus.pndng = 4'b0011;
      tick();
      check("oor_adv_pop", 64'(bus.pop), 64'h2);
      bus.pndng = '0;
      tick();
      check("oor_adv_push", 64'(bus.push), 64'h4);
      tick();

      // 6. Reset during PUSH of a unicast (pointer is 2, only driver 0 pending).
      bus.pndng    = 4'b0001;
      bus.D_pop[0] = 16'h0110;
      tick();
      check("rp_pop", 64'(bus.pop), 64'h1);
      bus.pndng = '0;
      tick();
      check("rp_push", 64'(bus.push), 64'h2);
      reset = 1'b1;
      tick();
      check("rp_after_push", 64'(bus.push),   64'h0);
      check("rp_after_drop", 64'(bus.drop),   64'h0);
      check("rp_after_busy", 64'(bus.busy),   64'h0);
      check("rp_after_data", 64'(bus.D_push), 64'h0);
      reset     = 1'b0;
      bus.pndng = 4'b1000;
      tick();
      check("rp_next_pop", 64'(bus.pop), 64'h8);
      bus.pndng = '0;
      tick();
      tick();

      // Reset during GRANT: popped packet discarded, no drop, pointer back to 0.
      bus.pndng = 4'b0010;
      tick();
      check("rg_pop", 64'(bus.pop), 64'h2);
      reset = 1'b1;
      bus.pndng = '0;
      tick();
      check("rg_push", 64'(bus.push), 64'h0);
      check("rg_drop", 64'(bus.drop), 64'h0);
      reset     = 1'b0;
      bus.pndng = 4'b1001;
      tick();
      check("rg_ptr0_pop", 64'(bus.pop), 64'h1);
      bus.pndng = '0;
      tick();
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
